apb4_plic_mt: RTL and testbench

APB4_PLIC_MT -- requirements
Module: apb4_plic_mt

---
 rtl/apb4_plic_mt.sv | 144 ++++++++++++++
 tb/tb_apb4_plic_mt.sv | 487 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb4_plic_mt.sv
// APB4 platform-level interrupt controller: per-source gateways with level/edge
// capture, per-target enable/threshold and claim/complete handshake.
module apb4_plic_mt #(
   parameter int SRC_NUM    = 31,
   parameter int TGT_NUM    = 2,
   parameter int PRIO_WIDTH = 3
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   input  logic [11:0]        paddr,
   input  logic [2:0]         pprot,
   input  logic               psel,
   input  logic               penable,
   input  logic               pwrite,
   input  logic [31:0]        pwdata,
   input  logic [3:0]         pstrb,
   output logic               pready,
   output logic [31:0]        prdata,
   output logic               pslverr,
   input  logic [SRC_NUM-1:0] irq_i,
   output logic [TGT_NUM-1:0] irq_o
);
   localparam int TW = (TGT_NUM > 1) ? $clog2(TGT_NUM) : 1;
   // Source vectors are 32 bits wide with bit s = source s; bit 0 never holds state.
   localparam logic [31:0] SRC_MASK = 32'(((33'd1 << SRC_NUM) - 33'd1) << 1);

   logic [31:0]           sync_p0, sync_p1, sync_p2;
   logic [31:0]           ip, inflight, eb, edge_mode;
   logic [31:0]           enable [TGT_NUM];
   logic [PRIO_WIDTH-1:0] thresh [TGT_NUM];
   logic [PRIO_WIDTH-1:0] prio [32];
   logic [4:0]            best_id [TGT_NUM];
   logic [PRIO_WIDTH-1:0] best_prio [TGT_NUM];

   logic          access, rd, we, bad, claim, cmp;
   logic          hit_zero, hit_prio, hit_pend, hit_edge, hit_tgt;
   logic [9:0]    idx;
   logic [3:0]    tgt;
   logic [1:0]    treg;
   logic [TW-1:0] t_sel;
   logic [31:0]   claim_vec, done, rise, ip_next, if_next, eb_next;
   logic          unused_prot;

   assign unused_prot = ^pprot;
   assign pready      = 1'b1;
   assign idx         = paddr[11:2];
   assign tgt         = paddr[7:4];
   assign treg        = paddr[3:2];
   assign t_sel       = tgt[TW-1:0];
   // Gated by reset so an access in flight when reset hits reports nothing.
   assign access      = psel & penable & rst_n_i;

   assign hit_zero = (paddr == 12'h000);
   assign hit_prio = (paddr[11:7] == 5'd0) && (paddr[1:0] == 2'd0) &&
                     (idx != 10'd0) && (idx <= 10'(SRC_NUM));
   assign hit_pend = (paddr == 12'h080);
   assign hit_edge = (paddr == 12'h084);
   assign hit_tgt  = (paddr[11:8] == 4'h1) && (paddr[1:0] == 2'd0) &&
                     (tgt < 4'(TGT_NUM)) && (treg != 2'd3);
   assign bad      = ~(hit_zero | hit_prio | hit_pend | hit_edge | hit_tgt) |
                     (pwrite & (hit_pend | (pstrb != 4'hF)));

   assign pslverr = access & bad;
   assign rd      = access & ~pwrite & ~bad;
   assign we      = access & pwrite & ~bad;
   assign claim   = rd & hit_tgt & (treg == 2'd2);
   assign cmp     = we & hit_tgt & (treg == 2'd2) & (pwdata != 32'd0) &
                    (pwdata <= 32'(SRC_NUM));

   assign claim_vec = claim ? ((32'd1 << best_id[t_sel]) & SRC_MASK) : '0;
   assign done      = cmp ? ((32'd1 << pwdata[4:0]) & inflight) : '0;
   assign rise      = sync_p1 & ~sync_p2;

   // A claim beats a same-edge gateway event: the event sees IP/IF as busy and
   // is either absorbed (level) or parked in EB (edge).
   assign ip_next = ((ip & ~claim_vec) | (done & eb) |
                     (sync_p1 & ~edge_mode & ~ip & ~inflight) |
                     (rise & edge_mode & ~ip & ~inflight)) & SRC_MASK;
   assign if_next = ((inflight & ~done) | claim_vec) & SRC_MASK;
   assign eb_next = ((eb & ~done) | (rise & edge_mode & (ip | inflight))) & SRC_MASK;

   // Strict '>' starting from the threshold gives lowest-ID tie-breaking.
   always_comb begin
      for (int t = 0; t < TGT_NUM; t++) begin
         best_prio[t] = thresh[t];
         best_id[t]   = '0;
         for (int s = 1; s <= SRC_NUM; s++) begin
            if (ip[s] && enable[t][s] && (prio[s] > best_prio[t])) begin
               best_prio[t] = prio[s];
               best_id[t]   = 5'(s);
            end
         end
      end
   end

   always_comb begin
      prdata = '0;
      if (rd) begin
         if (hit_prio)      prdata = 32'(prio[idx[4:0]]);
         else if (hit_pend) prdata = ip;
         else if (hit_edge) prdata = edge_mode;
         else if (hit_tgt) begin
            case (treg)
               2'd0:    prdata = enable[t_sel];
               2'd1:    prdata = 32'(thresh[t_sel]);
               default: prdata = 32'(best_id[t_sel]);
            endcase
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         sync_p0   <= '0;
         sync_p1   <= '0;
         sync_p2   <= '0;
         ip        <= '0;
         inflight  <= '0;
         eb        <= '0;
         edge_mode <= '0;
         irq_o     <= '0;
         for (int s = 0; s < 32; s++) prio[s] <= '0;
         for (int t = 0; t < TGT_NUM; t++) begin
            enable[t] <= '0;
            thresh[t] <= '0;
         end
      end else begin
         // stage p0/p1: two-flop synchroniser; p2 keeps the previous sample for edges
         sync_p0  <= 32'({irq_i, 1'b0}) & SRC_MASK;
         sync_p1  <= sync_p0;
         sync_p2  <= sync_p1;
         ip       <= ip_next;
         inflight <= if_next;
         eb       <= eb_next;
         for (int t = 0; t < TGT_NUM; t++) irq_o[t] <= (best_id[t] != 5'd0);
         if (we) begin
            if (hit_prio) prio[idx[4:0]] <= pwdata[PRIO_WIDTH-1:0];
            if (hit_edge) edge_mode <= pwdata & SRC_MASK;
            if (hit_tgt && (treg == 2'd0)) enable[t_sel] <= pwdata & SRC_MASK;
            if (hit_tgt && (treg == 2'd1)) thresh[t_sel] <= pwdata[PRIO_WIDTH-1:0];
         end
      end
   end
endmodule

// File: tb/tb_apb4_plic_mt.sv
// Self-checking bench for apb4_plic_mt: directed scenarios plus a randomized
// claim/complete run scored against a behavioural model of the controller.
module tb_apb4_plic_mt;
   localparam int SRC_NUM = 31;
   localparam int TGT_NUM = 2;

   logic               clk = 1'b0;
   logic               rst_n;
   logic [11:0]        paddr;
   logic [2:0]         pprot;
   logic               psel, penable, pwrite;
   logic [31:0]        pwdata;
   logic [3:0]         pstrb;
   logic               pready;
   logic [31:0]        prdata;
   logic               pslverr;
   logic [SRC_NUM-1:0] irq_i;
   logic [TGT_NUM-1:0] irq_o;

   int checks = 0;
   int errors = 0;

   // behavioural model state (bit/index s = source s)
   int          m_prio [32];
   logic [31:0] m_en   [TGT_NUM];
   int          m_thr  [TGT_NUM];
   logic [31:0] m_pend, m_inf, lines;

   apb4_plic_mt #(.SRC_NUM(SRC_NUM), .TGT_NUM(TGT_NUM), .PRIO_WIDTH(3)) dut (
      .clk_i(clk), .rst_n_i(rst_n), .paddr(paddr), .pprot(pprot), .psel(psel),
      .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
      .pready(pready), .prdata(prdata), .pslverr(pslverr), .irq_i(irq_i), .irq_o(irq_o)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic apb_write(input logic [11:0] a, input logic [31:0] d,
                            input logic [3:0] s, output logic e);
      @(posedge clk); #1;
      paddr = a; pwdata = d; pstrb = s; pwrite = 1'b1; psel = 1'b1; penable = 1'b0;
      @(posedge clk); #1;
      penable = 1'b1;
      @(negedge clk);
      e = pslverr;
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
   endtask

   task automatic apb_read(input logic [11:0] a, output logic [31:0] d, output logic e);
      @(posedge clk); #1;
      paddr = a; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
      @(posedge clk); #1;
      penable = 1'b1;
      @(negedge clk);
      d = prdata;
      e = pslverr;
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      irq_i = '0; paddr = '0; pprot = '0; psel = 1'b0; penable = 1'b0;
      pwrite = 1'b0; pwdata = '0; pstrb = 4'h0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   // Highest priority above threshold among pending enabled sources, lowest ID on ties.
   function automatic int model_best(int t);
      int top = 0;
      for (int s = 1; s <= SRC_NUM; s++)
         if (m_pend[s] && m_en[t][s] && m_prio[s] > m_thr[t] && m_prio[s] > top) top = m_prio[s];
      if (top == 0) return 0;
      for (int s = 1; s <= SRC_NUM; s++)
         if (m_pend[s] && m_en[t][s] && m_prio[s] == top) return s;
      return 0;
   endfunction

   task automatic test_reset();
      logic [31:0] d;
      logic        e;
      logic [11:0] addrs [7] = '{12'h000, 12'h014, 12'h080, 12'h084, 12'h110, 12'h104, 12'h118};
      do_reset();
      rst_n = 1'b0; irq_i = '1; paddr = 12'hFFC; psel = 1'b1; penable = 1'b1;
      #3;
      checks++;
      if (pslverr !== 1'b0 || prdata !== 32'd0 || irq_o !== 2'b00) begin
         errors++;
         $display("FAIL reset_outputs: pslverr=%b prdata=%h irq_o=%b, required 0/0/00", pslverr, prdata, irq_o);
      end
      psel = 1'b0; penable = 1'b0;
      repeat (4) @(posedge clk);
      checks++;
      if (irq_o !== 2'b00) begin
         errors++;
         $display("FAIL reset_irq_held: irq_o=%b, required 00", irq_o);
      end
      #1 rst_n = 1'b1; irq_i = '0;
      foreach (addrs[i]) begin
         apb_read(addrs[i], d, e);
         checks++;
         if (d !== 32'd0 || e !== 1'b0) begin
            errors++;
            $display("FAIL reset_reg_%h: data=%h err=%b, required 0/0", addrs[i], d, e);
         end
      end
   endtask

   task automatic test_level_latency();
      logic [31:0] d;
      logic        e;
      do_reset();
      apb_write(12'h00C, 32'd2, 4'hF, e);
      apb_write(12'h100, 32'h8, 4'hF, e);
      apb_write(12'h104, 32'd1, 4'hF, e);
      @(posedge clk); #1 irq_i[2] = 1'b1;
      @(posedge clk);          // edge N: first sample of the line
      @(posedge clk);          // N+1
      @(posedge clk); #1;      // N+2
      checks++;
      if (irq_o[0] !== 1'b0) begin
         errors++;
         $display("FAIL level_irq_n2: irq_o[0]=%b, required 0", irq_o[0]);
      end
      @(posedge clk); #1;      // N+3
      checks++;
      if (irq_o[0] !== 1'b1) begin
         errors++;
         $display("FAIL level_irq_n3: irq_o[0]=%b, required 1", irq_o[0]);
      end
      apb_read(12'h108, d, e);
      checks++;
      if (d !== 32'd3) begin
         errors++;
         $display("FAIL level_claim: got %0d, required 3", d);
      end
      repeat (2) @(posedge clk); #1;
      checks++;
      if (irq_o[0] !== 1'b0) begin
         errors++;
         $display("FAIL level_irq_after_claim: irq_o[0]=%b, required 0", irq_o[0]);
      end
      apb_read(12'h080, d, e);
      checks++;
      if (d !== 32'd0) begin
         errors++;
         $display("FAIL level_pend_inflight: got %h, required 0", d);
      end
      apb_write(12'h108, 32'd3, 4'hF, e);
      repeat (3) @(posedge clk); #1;
      checks++;
      if (irq_o[0] !== 1'b1) begin
         errors++;
         $display("FAIL level_repend_irq: irq_o[0]=%b, required 1", irq_o[0]);
      end
      apb_read(12'h080, d, e);
      checks++;
      if (d !== 32'h8) begin
         errors++;
         $display("FAIL level_repend_pend: got %h, required 00000008", d);
      end
   endtask

   task automatic test_priority();
      logic [31:0] d;
      logic        e;
      int          exp_ids [4] = '{9, 5, 7, 0};
      do_reset();
      apb_write(12'h014, 32'd4, 4'hF, e);
      apb_write(12'h01C, 32'd4, 4'hF, e);
      apb_write(12'h024, 32'd6, 4'hF, e);
      apb_write(12'h100, 32'h2A0, 4'hF, e);
      irq_i[4] = 1'b1; irq_i[6] = 1'b1; irq_i[8] = 1'b1;
      repeat (5) @(posedge clk); #1;
      checks++;
      if (irq_o[0] !== 1'b1) begin
         errors++;
         $display("FAIL prio_irq: irq_o[0]=%b, required 1", irq_o[0]);
      end
      foreach (exp_ids[i]) begin
         apb_read(12'h108, d, e);
         checks++;
         if (d !== 32'(exp_ids[i])) begin
            errors++;
            $display("FAIL prio_claim_%0d: got %0d, required %0d", i, d, exp_ids[i]);
         end
      end
      repeat (2) @(posedge clk); #1;
      checks++;
      if (irq_o[0] !== 1'b0) begin
         errors++;
         $display("FAIL prio_irq_drained: irq_o[0]=%b, required 0", irq_o[0]);
      end
   endtask

   task automatic pulse_src4();
      irq_i[3] = 1'b1;
      repeat (2) @(posedge clk); #1;
      irq_i[3] = 1'b0;
      repeat (2) @(posedge clk); #1;
   endtask

   task automatic test_edge();
      logic [31:0] d;
      logic        e;
      do_reset();
      apb_write(12'h084, 32'h10, 4'hF, e);
      apb_write(12'h010, 32'd1, 4'hF, e);
      apb_write(12'h100, 32'h10, 4'hF, e);
      pulse_src4();
      apb_read(12'h108, d, e);
      checks++;
      if (d !== 32'd4) begin
         errors++;
         $display("FAIL edge_claim1: got %0d, required 4", d);
      end
      repeat (3) pulse_src4();
      apb_read(12'h080, d, e);
      checks++;
      if (d !== 32'd0) begin
         errors++;
         $display("FAIL edge_pend_buffered: got %h, required 0", d);
      end
      apb_write(12'h108, 32'd4, 4'hF, e);
      repeat (3) @(posedge clk); #1;
      apb_read(12'h080, d, e);
      checks++;
      if (d !== 32'h10) begin
         errors++;
         $display("FAIL edge_repend: got %h, required 00000010", d);
      end
      apb_read(12'h108, d, e);
      checks++;
      if (d !== 32'd4) begin
         errors++;
         $display("FAIL edge_claim2: got %0d, required 4", d);
      end
      apb_write(12'h108, 32'd4, 4'hF, e);
      repeat (3) @(posedge clk); #1;
      apb_read(12'h108, d, e);
      checks++;
      if (d !== 32'd0) begin
         errors++;
         $display("FAIL edge_claim3: got %0d, required 0", d);
      end
   endtask

   task automatic test_multi_target();
      logic [31:0] d;
      logic        e;
      do_reset();
      apb_write(12'h008, 32'd3, 4'hF, e);
      apb_write(12'h100, 32'h4, 4'hF, e);
      apb_write(12'h110, 32'h4, 4'hF, e);
      apb_write(12'h114, 32'd7, 4'hF, e);
      irq_i[1] = 1'b1;
      repeat (5) @(posedge clk); #1;
      checks++;
      if (irq_o !== 2'b01) begin
         errors++;
         $display("FAIL multi_irq: irq_o=%b, required 01", irq_o);
      end
      apb_read(12'h108, d, e);
      checks++;
      if (d !== 32'd2) begin
         errors++;
         $display("FAIL multi_claim0: got %0d, required 2", d);
      end
      repeat (2) @(posedge clk); #1;
      checks++;
      if (irq_o !== 2'b00) begin
         errors++;
         $display("FAIL multi_irq_after: irq_o=%b, required 00", irq_o);
      end
   endtask

   task automatic test_thresh_drop();
      logic [31:0] d;
      logic        e;
      do_reset();
      apb_write(12'h018, 32'd5, 4'hF, e);
      apb_write(12'h100, 32'h40, 4'hF, e);
      irq_i[5] = 1'b1;
      repeat (5) @(posedge clk); #1;
      apb_write(12'h104, 32'd5, 4'hF, e);
      repeat (2) @(posedge clk); #1;
      checks++;
      if (irq_o[0] !== 1'b0) begin
         errors++;
         $display("FAIL thresh_drop_irq: irq_o[0]=%b, required 0", irq_o[0]);
      end
      apb_write(12'h104, 32'd4, 4'hF, e);
      repeat (2) @(posedge clk); #1;
      checks++;
      if (irq_o[0] !== 1'b1) begin
         errors++;
         $display("FAIL thresh_restore_irq: irq_o[0]=%b, required 1", irq_o[0]);
      end
      apb_write(12'h018, 32'd0, 4'hF, e);
      repeat (2) @(posedge clk); #1;
      checks++;
      if (irq_o[0] !== 1'b0) begin
         errors++;
         $display("FAIL prio_clear_irq: irq_o[0]=%b, required 0", irq_o[0]);
      end
      apb_read(12'h080, d, e);
      checks++;
      if (d !== 32'h40) begin
         errors++;
         $display("FAIL thresh_pend_kept: got %h, required 00000040", d);
      end
   endtask

   task automatic test_errors();
      logic [31:0] d;
      logic        e;
      do_reset();
      apb_write(12'h004, 32'd5, 4'hF, e);
      apb_write(12'h080, 32'hFFFF_FFFF, 4'hF, e);
      checks++;
      if (e !== 1'b1) begin
         errors++;
         $display("FAIL err_write_pend: pslverr=%b, required 1", e);
      end
      apb_read(12'h080, d, e);
      checks++;
      if (d !== 32'd0 || e !== 1'b0) begin
         errors++;
         $display("FAIL err_pend_unchanged: data=%h err=%b, required 0/0", d, e);
      end
      apb_write(12'h004, 32'd2, 4'h3, e);
      checks++;
      if (e !== 1'b1) begin
         errors++;
         $display("FAIL err_partial_strb: pslverr=%b, required 1", e);
      end
      apb_read(12'h004, d, e);
      checks++;
      if (d !== 32'd5) begin
         errors++;
         $display("FAIL err_prio_unchanged: got %0d, required 5", d);
      end
      apb_read(12'hFFC, d, e);
      checks++;
      if (e !== 1'b1 || d !== 32'd0) begin
         errors++;
         $display("FAIL err_read_unmapped: err=%b data=%h, required 1/0", e, d);
      end
      apb_write(12'hFFC, 32'h1234, 4'hF, e);
      checks++;
      if (e !== 1'b1) begin
         errors++;
         $display("FAIL err_write_unmapped: pslverr=%b, required 1", e);
      end
      apb_write(12'h10C, 32'h1, 4'hF, e);
      checks++;
      if (e !== 1'b1) begin
         errors++;
         $display("FAIL err_write_hole: pslverr=%b, required 1", e);
      end
      apb_write(12'h108, 32'd0, 4'hF, e);
      checks++;
      if (e !== 1'b0) begin
         errors++;
         $display("FAIL err_complete0: pslverr=%b, required 0", e);
      end
   endtask

   task automatic test_reset_mid_access();
      logic [31:0] d;
      logic        e;
      do_reset();
      @(posedge clk); #1;
      paddr = 12'h004; pwdata = 32'd7; pstrb = 4'hF; pwrite = 1'b1; psel = 1'b1; penable = 1'b0;
      @(posedge clk); #1;
      penable = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (pslverr !== 1'b0 || prdata !== 32'd0) begin
         errors++;
         $display("FAIL midreset_outputs: pslverr=%b prdata=%h, required 0/0", pslverr, prdata);
      end
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      apb_read(12'h004, d, e);
      checks++;
      if (d !== 32'd0) begin
         errors++;
         $display("FAIL midreset_aborted: got %0d, required 0", d);
      end
      apb_write(12'h004, 32'd7, 4'hF, e);
      apb_read(12'h004, d, e);
      checks++;
      if (d !== 32'd7 || e !== 1'b0) begin
         errors++;
         $display("FAIL midreset_first_access: data=%0d err=%b, required 7/0", d, e);
      end
   endtask

   task automatic test_random();
      logic [31:0] d;
      logic        e;
      int          t, exp, id;
      for (int round = 0; round < 3; round++) begin
         do_reset();
         m_pend = '0; m_inf = '0;
         for (int s = 1; s <= SRC_NUM; s++) begin
            m_prio[s] = $urandom_range(0, 7);
            apb_write(12'(4 * s), 32'(m_prio[s]), 4'hF, e);
         end
         for (int k = 0; k < TGT_NUM; k++) begin
            m_en[k]  = $urandom & 32'hFFFF_FFFE;
            m_thr[k] = $urandom_range(0, 3);
            apb_write(12'(12'h100 + 16 * k), m_en[k], 4'hF, e);
            apb_write(12'(12'h104 + 16 * k), 32'(m_thr[k]), 4'hF, e);
         end
         lines = $urandom & 32'hFFFF_FFFE;
         irq_i = lines[31:1];
         repeat (6) @(posedge clk); #1;
         m_pend = lines;
         apb_read(12'h080, d, e);
         checks++;
         if (d !== m_pend) begin
            errors++;
            $display("FAIL rand_pend_r%0d: got %h, required %h", round, d, m_pend);
         end
         for (int step = 0; step < 12; step++) begin
            t   = $urandom_range(0, TGT_NUM - 1);
            exp = model_best(t);
            checks++;
            if (irq_o[t] !== (exp != 0)) begin
               errors++;
               $display("FAIL rand_irq_r%0d_s%0d: irq_o[%0d]=%b, required %b", round, step, t, irq_o[t], exp != 0);
            end
            apb_read(12'(12'h108 + 16 * t), d, e);
            checks++;
            if (d !== 32'(exp)) begin
               errors++;
               $display("FAIL rand_claim_r%0d_s%0d: target %0d got %0d, required %0d", round, step, t, d, exp);
            end
            if (exp != 0) begin
               m_pend[exp] = 1'b0;
               m_inf[exp]  = 1'b1;
            end
            repeat (2) @(posedge clk); #1;
            if ($urandom_range(0, 1) == 1) begin
               id = $urandom_range(0, 33);
               apb_write(12'(12'h108 + 16 * $urandom_range(0, TGT_NUM - 1)), 32'(id), 4'hF, e);
               checks++;
               if (e !== 1'b0) begin
                  errors++;
                  $display("FAIL rand_complete_err_r%0d_s%0d: pslverr=%b, required 0", round, step, e);
               end
               if (id >= 1 && id <= SRC_NUM && m_inf[id]) begin
                  m_inf[id] = 1'b0;
                  if (lines[id]) m_pend[id] = 1'b1;
               end
               repeat (3) @(posedge clk); #1;
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_level_latency();
      test_priority();
      test_edge();
      test_multi_target();
      test_thresh_drop();
      test_errors();
      test_reset_mid_access();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
